// File: rtl/frame_swap_ctrl.sv
// frame_swap_ctrl: double-buffer bank swap responder for render_done/render_ack, vblank-aligned with frame-rate cap.
// Optional statistics counters (frame_count, repeat_count) are built only when SWAP_STATS_EN is defined.
module frame_swap_ctrl #(
    parameter int MIN_FRAMES = 2,
    parameter int CNT_W      = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             new_frame,
    input  logic             render_done,
    input  logic             hold_swap,
    output logic             render_ack,
    output logic             front_sel,
    output logic [CNT_W-1:0] frame_count,
    output logic [CNT_W-1:0] repeat_count
);
    localparam int VW = $clog2(MIN_FRAMES + 1);
    localparam logic [VW-1:0] VB_MAX = VW'(MIN_FRAMES);
    localparam logic [VW-1:0] VB_THR = VW'(MIN_FRAMES - 1);

    typedef enum logic [1:0] {RENDER, ACK, DROP} state_t;

    state_t        state_q, state_d;
    logic [VW-1:0] vb_cnt_q, vb_cnt_d;
    logic          front_sel_q, front_sel_d;
    logic          swap_ok;

    // vb_cnt+1 >= MIN_FRAMES rewritten as vb_cnt >= MIN_FRAMES-1 to stay in VW bits
    assign swap_ok = state_q == RENDER && new_frame && render_done && !hold_swap && vb_cnt_q >= VB_THR;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state_q <= RENDER;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RENDER:  state_d = swap_ok ? ACK : RENDER;
            ACK:     state_d = DROP;
            DROP:    state_d = render_done ? DROP : RENDER;
            default: state_d = RENDER;
        endcase
    end

    always_comb begin
        render_ack = state_q == ACK;
        front_sel  = front_sel_q;
    end

    // Clear on the swap edge wins; any later new_frame (even in ACK) counts again.
    always_comb begin
        vb_cnt_d    = swap_ok ? '0 : (new_frame && vb_cnt_q != VB_MAX) ? vb_cnt_q + 1'b1 : vb_cnt_q;
        front_sel_d = swap_ok ? ~front_sel_q : front_sel_q;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            vb_cnt_q    <= '0;
            front_sel_q <= 1'b0;
        end else begin
            vb_cnt_q    <= vb_cnt_d;
            front_sel_q <= front_sel_d;
        end
    end

`ifdef SWAP_STATS_EN
    logic [CNT_W-1:0] frame_count_q, frame_count_d;
    logic [CNT_W-1:0] repeat_count_q, repeat_count_d;

    always_comb begin
        frame_count_d  = swap_ok ? frame_count_q + 1'b1 : frame_count_q;
        repeat_count_d = (state_q == RENDER && new_frame && !render_done && repeat_count_q != '1)
                         ? repeat_count_q + 1'b1 : repeat_count_q;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            frame_count_q  <= '0;
            repeat_count_q <= '0;
        end else begin
            frame_count_q  <= frame_count_d;
            repeat_count_q <= repeat_count_d;
        end
    end

    assign frame_count  = frame_count_q;
    assign repeat_count = repeat_count_q;
`else
    assign frame_count  = '0;
    assign repeat_count = '0;
`endif

    a_ack_single: assert property (@(posedge Clk) disable iff (Reset) render_ack |=> !render_ack);
    a_bank_on_ack: assert property (@(posedge Clk) disable iff (Reset) $changed(front_sel) |-> render_ack);

endmodule
